// File: rtl/ledcube_pkg.sv
// Constants and types shared between the frame loader and the refresh side
// of the LED cube.
package ledcube_pkg;

    // One frame is an 8x8x8 voxel cube, one byte per voxel.
    localparam int         ADDR_WIDTH  = 9;
    localparam int         FRAME_BYTES = 512;
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    // Frame loader protocol states.
    typedef enum logic [1:0] {
        SYNC  = 2'd0,  // hunting for the sync byte
        LOAD  = 2'd1,  // receiving voxel bytes
        CHECK = 2'd2,  // waiting for the checksum byte
        DONE  = 2'd3   // one-cycle back-off before hunting again
    } loader_state_e;

endpackage

// File: rtl/frame_loader_idle_timer.sv
// Idle watchdog: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CYCLES-1 idle cycles have elapsed. Also intended for
// the I2C watchdog, so it knows nothing about frames.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry is combinational on the count so the owner can react in the
    // same cycle the limit is reached.
    assign expired_o = (count_q == LAST);

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frame_loader.sv
// Frame loader: parses sync + FRAME_BYTES voxel bytes + XOR checksum from a
// valid/ready byte stream and writes the voxels into the frame RAM with one
// clock of latency.
module frame_loader
    import ledcube_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = ledcube_pkg::SYNC_BYTE,
    parameter int         FRAME_BYTES    = ledcube_pkg::FRAME_BYTES,
    parameter int         ADDR_WIDTH     = ledcube_pkg::ADDR_WIDTH,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [7:0]            ram_data_in,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_error
);

    // Index is one bit wider than the address so the last-byte compare is
    // unambiguous.
    localparam int IW = ADDR_WIDTH + 1;
    localparam logic [IW-1:0] LAST_INDEX = IW'(FRAME_BYTES - 1);

    loader_state_e          state_q, state_d;
    logic [IW-1:0]          index_q, index_d;
    logic [7:0]             csum_q, csum_d;
    logic                   wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   live_q;

    logic accept;
    logic in_frame;
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;
    logic timeout;

    // Input handshake and frame-activity decode.
    always_comb begin
        in_frame = (state_q == LOAD) || (state_q == CHECK);
        // live_q holds ready low for the first cycle after reset release.
        in_ready = live_q && (state_q != DONE);
        accept   = in_valid && in_ready;
        // Timer runs only while inside a frame and restarts on every byte.
        tmr_clear  = !in_frame || accept;
        tmr_enable = in_frame && !accept;
        // An accept in the expiry cycle takes precedence over the timeout.
        timeout    = in_frame && !accept && tmr_expired;
    end

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i     (clock),
        .rst_ni    (reset),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_enable),
        .expired_o (tmr_expired)
    );

    // Next-state and registered-output logic for the frame parser.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        csum_d  = csum_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            SYNC: begin
                // Anything other than the sync byte is silently dropped.
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = LOAD;
                    index_d = '0;
                    csum_d  = '0;
                end
            end

            LOAD: begin
                // Sync-valued bytes here are plain voxel data.
                if (accept) begin
                    wr_d    = 1'b1;
                    addr_d  = index_q[ADDR_WIDTH-1:0];
                    data_d  = in_data;
                    csum_d  = csum_q ^ in_data;
                    index_d = index_q + 1'b1;
                    if (index_q == LAST_INDEX) begin
                        state_d = CHECK;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end

            CHECK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = SYNC;
            end

            default: begin
                state_d = SYNC;
            end
        endcase
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= SYNC;
            index_q <= '0;
            csum_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            csum_q  <= csum_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    assign ram_write   = wr_q;
    assign ram_address = addr_q;
    assign ram_data_in = data_q;
    assign busy        = in_frame;
    assign frame_done  = done_q;
    assign frame_error = err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader with a short timeout.
module tb_frame_loader;

    logic       clock;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ram_write;
    logic [8:0] ram_address;
    logic [7:0] ram_data_in;
    logic       busy;
    logic       frame_done;
    logic       frame_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];
    int         ndone = 0;
    int         nerr  = 0;
    int         nboth = 0;

    frame_loader #(
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ram_write   (ram_write),
        .ram_address (ram_address),
        .ram_data_in (ram_data_in),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record RAM writes and status pulses, sampled mid-cycle.
    always @(negedge clock) begin
        if (ram_write === 1'b1) begin
            wa.push_back(ram_address);
            wd.push_back(ram_data_in);
            wc.push_back(cyc);
        end
        if (frame_done === 1'b1) ndone++;
        if (frame_error === 1'b1) nerr++;
        if (frame_done === 1'b1 && frame_error === 1'b1) nboth++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte from a negedge and return at the negedge after it is taken.
    task automatic send(input logic [7:0] b);
        int t;
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (t >= 20) chk("ready_wait", 32'(t), 32'd0);
        @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] last);
        send(8'hA5);
        for (int i = 0; i < 512; i++) send(8'(i));
        send(last);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // 512 writes from base: address i, data i[7:0], consecutive cycles.
    task automatic check_frame(input string tag, input int base);
        int ba, bd, bg;
        ba = 0; bd = 0; bg = 0;
        chk({tag, "_nwr"}, 32'(wa.size() - base), 32'd512);
        if (wa.size() - base >= 512) begin
            for (int i = 0; i < 512; i++) begin
                if (wa[base+i] !== 9'(i)) ba++;
                if (wd[base+i] !== 8'(i)) bd++;
                if (wc[base+i] != wc[base] + i) bg++;
            end
        end else begin
            ba = 1;
        end
        chk({tag, "_addr"}, 32'(ba), 32'd0);
        chk({tag, "_data"}, 32'(bd), 32'd0);
        chk({tag, "_gap"},  32'(bg), 32'd0);
    endtask

    initial begin
        int base, d0, e0, first;

        // Reset held with a sync byte on the bus.
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        idle(3);
        chk("rst_write", {31'b0, ram_write}, 32'd0);
        chk("rst_addr",  {23'b0, ram_address}, 32'd0);
        chk("rst_data",  {24'b0, ram_data_in}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_flags", {30'b0, frame_done, frame_error}, 32'd0);
        chk("rst_nwr",   32'(wa.size()), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("ready_after_rel", {31'b0, in_ready}, 32'd0);
        @(negedge clock);
        chk("ready_one_later", {31'b0, in_ready}, 32'd1);

        // Good frame: checksum of 0..255 twice is zero.
        base = wa.size(); d0 = ndone; e0 = nerr;
        send(8'hA5);
        chk("busy_in_load", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 512; i++) send(8'(i));
        send(8'h00);
        in_valid = 1'b0;
        chk("done_ready_low", {31'b0, in_ready}, 32'd0);
        idle(4);
        check_frame("good", base);
        chk("good_done", 32'(ndone - d0), 32'd1);
        chk("good_err",  32'(nerr - e0), 32'd0);
        chk("good_busy", {31'b0, busy}, 32'd0);

        // Bad checksum.
        base = wa.size(); d0 = ndone; e0 = nerr;
        send_frame(8'h01);
        idle(4);
        check_frame("badck", base);
        chk("badck_done", 32'(ndone - d0), 32'd0);
        chk("badck_err",  32'(nerr - e0), 32'd1);

        // Noise before sync is dropped.
        base = wa.size(); d0 = ndone; e0 = nerr;
        send(8'h3C);
        send(8'h00);
        in_valid = 1'b0;
        idle(2);
        chk("noise_nwr", 32'(wa.size() - base), 32'd0);
        chk("noise_err", 32'(nerr - e0), 32'd0);
        chk("noise_busy", {31'b0, busy}, 32'd0);
        send_frame(8'h00);
        idle(4);
        check_frame("afternoise", base);
        chk("afternoise_done", 32'(ndone - d0), 32'd1);

        // Timeout: 10 voxels then silence; error follows the 50th idle cycle.
        base = wa.size(); d0 = ndone; e0 = nerr;
        send(8'hA5);
        for (int i = 0; i < 10; i++) send(8'(i));
        in_valid = 1'b0;
        first = -1;
        for (int k = 1; k <= 60; k++) begin
            if (frame_error === 1'b1 && first < 0) first = k;
            @(negedge clock);
        end
        chk("to_when",  32'(first), 32'd51);
        chk("to_nerr",  32'(nerr - e0), 32'd1);
        chk("to_nwr",   32'(wa.size() - base), 32'd10);
        chk("to_busy",  {31'b0, busy}, 32'd0);
        base = wa.size(); d0 = ndone;
        send_frame(8'h00);
        idle(4);
        check_frame("afterto", base);
        chk("afterto_done", 32'(ndone - d0), 32'd1);

        // Reset mid-frame, then a clean frame.
        send(8'hA5);
        for (int i = 0; i < 100; i++) send(8'(i));
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("midrst_busy",  {31'b0, busy}, 32'd0);
        chk("midrst_write", {31'b0, ram_write}, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(2);
        base = wa.size(); d0 = ndone; e0 = nerr;
        send_frame(8'h00);
        idle(4);
        check_frame("afterrst", base);
        chk("afterrst_done", 32'(ndone - d0), 32'd1);
        chk("afterrst_err",  32'(nerr - e0), 32'd0);

        chk("never_both", 32'(nboth), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a hang.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
Upstream stage of the 512x8 frame RAM that feeds RefreshController. It consumes a host byte stream from a UART RX through a valid/ready interface. It parses framed packets of the form sync byte, 512 voxel bytes, then an XOR checksum. Voxel bytes are written into the RAM write port (write, address, data) that is currently tied off at the top level.

Parameters:
SYNC_BYTE, 8'hA5, header byte that opens a frame
FRAME_BYTES, 512, voxel bytes per frame (8x8x8 cube)
ADDR_WIDTH, 9, RAM address width; FRAME_BYTES must equal 2**ADDR_WIDTH
TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame before abort

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid this cycle
in_ready  output  1  loader accepts byte this cycle
ram_write  output  1  write strobe to block_mem
ram_address  output  ADDR_WIDTH  RAM write address
ram_data_in  output  8  RAM write data
busy  output  1  high while a frame is being received (LOAD or CHECK)
frame_done  output  1  one-cycle pulse: frame received, checksum good
frame_error  output  1  one-cycle pulse: checksum mismatch or timeout

Behaviour:
- Accept is defined as in_valid & in_ready. in_ready = 1 in SYNC, LOAD and CHECK, and 0 in the cycle after reset release and in DONE.
- Reset (reset=0, asynchronous) forces: state=SYNC, ram_write=0, ram_address=0, ram_data_in=0, busy=0, frame_done=0, frame_error=0, index=0, checksum=0, timer=0. Reset mid-frame abandons the frame. RAM contents already written are left as is.
- State SYNC: an accepted byte equal to SYNC_BYTE moves to LOAD, clears index and checksum, clears timer. Any other byte is discarded; no RAM write and no error.
- State LOAD: an accepted byte at cycle N produces, registered at N+1: ram_write=1, ram_address=index, ram_data_in=byte. checksum ^= byte and index++ (ADDR_WIDTH+1 bit counter). After the byte with index FRAME_BYTES-1 is accepted, go to CHECK. ram_write is high exactly one cycle per accepted byte. Back-to-back bytes (in_valid held high) write on consecutive cycles.
- State CHECK: an accepted byte is compared with checksum (XOR of all 512 voxel bytes; the sync byte is excluded). Match: frame_done=1 for one cycle. Mismatch: frame_error=1 for one cycle. Both cases go to DONE.
- State DONE: a single cycle with in_ready=0, then return to SYNC.
- Timeout: in LOAD and CHECK the timer increments every cycle with no accept and clears on each accept. When the timer reaches TIMEOUT_CYCLES-1 without an accept, frame_error pulses and the state goes to DONE. A byte accepted in that same cycle wins: the timer clears and there is no error.
- busy = 1 in LOAD and CHECK, 0 otherwise.
- A sync byte value appearing inside LOAD is ordinary data; there is no resync.
- frame_done and frame_error are never high together. Both are registered outputs.
- Write latency: 1 clock from accept to ram_write.

Decomposition:
- Shared package ledcube_pkg holds:
  - FRAME_BYTES, ADDR_WIDTH, SYNC_BYTE constants, shared with RefreshController
  - loader state typedef {SYNC, LOAD, CHECK, DONE}
- One natural sub-module: idle_timer, with clear, enable, TIMEOUT_CYCLES parameter and an expired output. It is reusable for the I2C watchdog.

Test Plan:
- Reset with reset=0 while in_valid=1, in_data=8'hA5 -> all outputs 0, no RAM writes. Release -> in_ready rises after one cycle.
- Send A5, then bytes 0..255,0..255 back-to-back (checksum 8'h00), then 8'h00 -> 512 writes at addresses 0..511, each with data = address[7:0], consecutive cycles. frame_done pulses once, busy falls.
- Same frame with last byte 8'h01 -> all 512 writes occur, frame_error pulses once, frame_done stays 0.
- Send 8'h3C, 8'h00, then A5 plus a valid frame -> the first two bytes cause no write and no error. The frame loads normally starting at address 0.
- Send A5 plus 10 bytes, then idle for TIMEOUT_CYCLES (set to 50) -> frame_error at the 50th idle cycle, state returns to SYNC. A following full frame loads from address 0.
- Assert reset after 100 voxel bytes, then release and send a full frame -> that frame writes addresses 0..511 and frame_done pulses.
